// File: rtl/edge_frame_sink_if.sv
// Bus bundle for edge_frame_sink: upstream FWFT FIFO read port plus downstream
// FIFO write port with raster sideband.
interface edge_frame_sink_if #(
  parameter int unsigned DATA_WIDTH = 24
);
  // Upstream FIFO read port
  logic [DATA_WIDTH-1:0] in_dout;
  logic                  in_empty;
  logic                  in_rd_en;
  // Downstream FIFO write port
  logic [DATA_WIDTH-1:0] out_din;
  logic                  out_full;
  logic                  out_wr_en;
  logic                  out_sof;
  logic                  out_eol;
  logic                  out_eof;

  // Sink side (the edge_frame_sink block itself)
  modport slave (
    input  in_dout, in_empty, out_full,
    output in_rd_en, out_din, out_wr_en, out_sof, out_eol, out_eof
  );

  // Environment side (upstream FIFO head + downstream FIFO status)
  modport master (
    output in_dout, in_empty, out_full,
    input  in_rd_en, out_din, out_wr_en, out_sof, out_eol, out_eof
  );
endinterface

// File: rtl/edge_frame_sink.sv
// edge_frame_sink: pops pixels from the edge-detect output FIFO, re-emits them
// through a one-word holding register with SOF/EOL/EOF sideband, and counts
// completed frames. Optional per-frame checksum is built when the macro
// EDGE_SINK_CHECKSUM_EN is defined; otherwise frame_checksum is tied to 0.
module edge_frame_sink #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned WIDTH      = 720,
  parameter int unsigned HEIGHT     = 540
) (
  input  logic                 clock,
  input  logic                 reset,
  edge_frame_sink_if.slave     bus,
  output logic                 frame_done,
  output logic [15:0]          frame_cnt,
  output logic [31:0]          frame_checksum
);

  localparam int unsigned COL_W = $clog2(WIDTH);
  localparam int unsigned ROW_W = $clog2(HEIGHT);
  localparam int unsigned CNT_W = 16;
  localparam int unsigned CK_W  = 32;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  // Holding register occupancy: the whole control FSM
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  state_e                  state_q,      state_d;
  logic [DATA_WIDTH-1:0]   data_q,       data_d;
  logic                    sof_q,        sof_d;
  logic                    eol_q,        eol_d;
  logic                    eof_q,        eof_d;
  logic [COL_W-1:0]        col_q,        col_d;
  logic [ROW_W-1:0]        row_q,        row_d;
  logic [CNT_W-1:0]        frame_cnt_q,  frame_cnt_d;
  logic                    frame_done_q, frame_done_d;

  logic                    pop_c;
  logic                    push_c;

  // Handshake: write when holding and downstream has room; pop when the
  // register is free or is being drained this cycle. Both are forced low in reset.
  always_comb begin
    push_c = ~reset & (state_q == ST_HOLD) & ~bus.out_full;
    pop_c  = ~reset & ~bus.in_empty & ((state_q == ST_EMPTY) | ~bus.out_full);
  end

  // Next state: load on pop (sideband from raster position), drain on write-only
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    sof_d        = sof_q;
    eol_d        = eol_q;
    eof_d        = eof_q;
    col_d        = col_q;
    row_d        = row_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;

    if (pop_c) begin
      state_d = ST_HOLD;
      data_d  = bus.in_dout;
      sof_d   = (col_q == '0) && (row_q == '0);
      eol_d   = (col_q == COL_LAST);
      eof_d   = (col_q == COL_LAST) && (row_q == ROW_LAST);
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end else if (push_c) begin
      state_d = ST_EMPTY;
    end

    if (push_c && eof_q) begin
      frame_cnt_d  = frame_cnt_q + CNT_W'(1);
      frame_done_d = 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      data_q       <= '0;
      sof_q        <= 1'b0;
      eol_q        <= 1'b0;
      eof_q        <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      sof_q        <= sof_d;
      eol_q        <= eol_d;
      eof_q        <= eof_d;
      col_q        <= col_d;
      row_q        <= row_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef EDGE_SINK_CHECKSUM_EN
  logic [CK_W-1:0] acc_q, acc_d;
  logic [CK_W-1:0] ck_q,  ck_d;
  logic [CK_W-1:0] sum_c;

  // Running sum of written pixels; the EOF write publishes it and restarts
  always_comb begin
    sum_c = acc_q + CK_W'(data_q);
    acc_d = acc_q;
    ck_d  = ck_q;
    if (push_c) begin
      if (eof_q) begin
        acc_d = '0;
        ck_d  = sum_c;
      end else begin
        acc_d = sum_c;
      end
    end
  end

  // Checksum registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      ck_q  <= '0;
    end else begin
      acc_q <= acc_d;
      ck_q  <= ck_d;
    end
  end

  assign frame_checksum = ck_q;
`else
  assign frame_checksum = '0;
`endif

  assign bus.in_rd_en  = pop_c;
  assign bus.out_wr_en = push_c;
  assign bus.out_din   = data_q;
  assign bus.out_sof   = sof_q;
  assign bus.out_eol   = eol_q;
  assign bus.out_eof   = eof_q;
  assign frame_done    = frame_done_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_edge_frame_sink.sv
// Directed bench for edge_frame_sink at WIDTH=4, HEIGHT=2.
module tb_edge_frame_sink;

  localparam int unsigned DW = 24;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
`ifdef EDGE_SINK_CHECKSUM_EN
  localparam bit CK_ON = 1'b1;
`else
  localparam bit CK_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic [31:0] frame_checksum;

  edge_frame_sink_if #(.DATA_WIDTH(DW)) bus ();

  edge_frame_sink #(.DATA_WIDTH(DW), .WIDTH(W), .HEIGHT(H)) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
    .frame_done     (frame_done),
    .frame_cnt      (frame_cnt),
    .frame_checksum (frame_checksum)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor, sampled between negedge and the next active edge
  typedef struct {
    logic [23:0] d;
    logic [2:0]  sb;
  } wr_t;
  wr_t         wq[$];
  int          done_cnt = 0;
  logic [31:0] last_ck  = '0;

  always begin
    @(negedge clock);
    #3;
    if (bus.out_wr_en === 1'b1)
      wq.push_back('{bus.out_din, {bus.out_sof, bus.out_eol, bus.out_eof}});
    if (frame_done === 1'b1) begin
      done_cnt++;
      last_ck = frame_checksum;
    end
  end

  // Per-cycle vector: inputs then expected outputs in that same cycle
  typedef struct {
    logic        empty;
    logic [23:0] dout;
    logic        full;
    logic        rd;
    logic        wr;
    logic        chk;
    logic [23:0] din;
    logic [2:0]  sb;
    logic        done;
    logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(logic e, logic [23:0] d, logic f, logic rd, logic wr,
                              logic chk, logic [23:0] din, logic [2:0] sb,
                              logic done, logic [15:0] cnt);
    vec_t v;
    v = '{e, d, f, rd, wr, chk, din, sb, done, cnt};
    return v;
  endfunction

  // Push n pixels (base+idx, or base repeated), optionally idling every other cycle
  task automatic stream(input string tag, input int n, input logic [23:0] base,
                        input bit gap, input bit same,
                        input logic [15:0] exp_cnt, input logic [31:0] exp_ck);
    int idx = 0;
    int cyc = 0;
    logic [23:0] px;
    wq.delete();
    done_cnt = 0;
    while ((idx < n || wq.size() < n) && cyc < 300) begin
      @(negedge clock);
      if (idx < n && !(gap && cyc[0])) begin
        bus.in_empty = 1'b0;
        bus.in_dout  = same ? base : base + 24'(idx);
      end else begin
        bus.in_empty = 1'b1;
      end
      #1;
      if (bus.in_rd_en === 1'b1) idx++;
      cyc++;
    end
    bus.in_empty = 1'b1;
    repeat (3) @(negedge clock);
    #4;
    check({tag, "_writes"}, 32'(wq.size()), 32'(n));
    for (int k = 0; k < n && k < wq.size(); k++) begin
      px = same ? base : base + 24'(k);
      check($sformatf("%s_data%0d", tag, k), 32'(wq[k].d), 32'(px));
      check($sformatf("%s_sb%0d", tag, k), 32'(wq[k].sb),
            32'({(k % 8) == 0, (k % 4) == 3, (k % 8) == 7}));
    end
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'(n / 8));
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
    check({tag, "_checksum"}, last_ck, CK_ON ? exp_ck : 32'h0);
  endtask

  vec_t tv[26];

  initial begin
    // Streaming frame: sideband and single frame_done pulse
    tv[0]  = mk(0, 24'h1, 0, 1, 0, 0, 24'h0, 3'b000, 0, 16'd0);
    tv[1]  = mk(0, 24'h2, 0, 1, 1, 1, 24'h1, 3'b100, 0, 16'd0);
    tv[2]  = mk(0, 24'h3, 0, 1, 1, 1, 24'h2, 3'b000, 0, 16'd0);
    tv[3]  = mk(0, 24'h4, 0, 1, 1, 1, 24'h3, 3'b000, 0, 16'd0);
    tv[4]  = mk(0, 24'h5, 0, 1, 1, 1, 24'h4, 3'b010, 0, 16'd0);
    tv[5]  = mk(0, 24'h6, 0, 1, 1, 1, 24'h5, 3'b000, 0, 16'd0);
    tv[6]  = mk(0, 24'h7, 0, 1, 1, 1, 24'h6, 3'b000, 0, 16'd0);
    tv[7]  = mk(0, 24'h8, 0, 1, 1, 1, 24'h7, 3'b000, 0, 16'd0);
    tv[8]  = mk(1, 24'h0, 0, 0, 1, 1, 24'h8, 3'b011, 0, 16'd0);
    tv[9]  = mk(1, 24'h0, 0, 0, 0, 0, 24'h0, 3'b000, 1, 16'd1);
    // Backpressure: 5 cycles of full while holding 0x3
    tv[10] = mk(0, 24'h1, 0, 1, 0, 0, 24'h0, 3'b000, 0, 16'd1);
    tv[11] = mk(0, 24'h2, 0, 1, 1, 1, 24'h1, 3'b100, 0, 16'd1);
    tv[12] = mk(0, 24'h3, 0, 1, 1, 1, 24'h2, 3'b000, 0, 16'd1);
    for (int i = 13; i <= 17; i++)
      tv[i] = mk(0, 24'h4, 1, 0, 0, 1, 24'h3, 3'b000, 0, 16'd1);
    tv[18] = mk(0, 24'h4, 0, 1, 1, 1, 24'h3, 3'b000, 0, 16'd1);
    tv[19] = mk(0, 24'h5, 0, 1, 1, 1, 24'h4, 3'b010, 0, 16'd1);
    tv[20] = mk(0, 24'h6, 0, 1, 1, 1, 24'h5, 3'b000, 0, 16'd1);
    tv[21] = mk(0, 24'h7, 0, 1, 1, 1, 24'h6, 3'b000, 0, 16'd1);
    tv[22] = mk(0, 24'h8, 0, 1, 1, 1, 24'h7, 3'b000, 0, 16'd1);
    tv[23] = mk(1, 24'h0, 0, 0, 1, 1, 24'h8, 3'b011, 0, 16'd1);
    tv[24] = mk(1, 24'h0, 0, 0, 0, 0, 24'h0, 3'b000, 1, 16'd2);
    tv[25] = mk(1, 24'h0, 0, 0, 0, 0, 24'h0, 3'b000, 0, 16'd2);

    reset        = 1'b1;
    bus.in_empty = 1'b1;
    bus.in_dout  = '0;
    bus.out_full = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("por_frame_cnt", 32'(frame_cnt), 32'h0);
    check("por_wr_en", 32'(bus.out_wr_en), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 26; i++) begin
      @(negedge clock);
      bus.in_empty = tv[i].empty;
      bus.in_dout  = tv[i].dout;
      bus.out_full = tv[i].full;
      #2;
      check($sformatf("v%0d_rd_en", i), 32'(bus.in_rd_en), 32'(tv[i].rd));
      check($sformatf("v%0d_wr_en", i), 32'(bus.out_wr_en), 32'(tv[i].wr));
      check($sformatf("v%0d_done", i), 32'(frame_done), 32'(tv[i].done));
      check($sformatf("v%0d_cnt", i), 32'(frame_cnt), 32'(tv[i].cnt));
      if (tv[i].chk) begin
        check($sformatf("v%0d_din", i), 32'(bus.out_din), 32'(tv[i].din));
        check($sformatf("v%0d_sb", i), 32'({bus.out_sof, bus.out_eol, bus.out_eof}),
              32'(tv[i].sb));
      end
    end
    bus.out_full = 1'b0;

    // Starvation: empty toggles each cycle over two frames (0x10..0x1F)
    stream("starve", 16, 24'h10, 1'b1, 1'b0, 16'd4, 32'h0000_00DC);

    // Mid-frame reset with a pixel held: everything drops to 0 at once
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      bus.in_empty = 1'b0;
      bus.in_dout  = 24'hA1 + 24'(i);
    end
    @(negedge clock);
    bus.in_dout = 24'hA4;
    reset       = 1'b1;
    #1;
    check("rst_rd_en", 32'(bus.in_rd_en), 32'h0);
    check("rst_wr_en", 32'(bus.out_wr_en), 32'h0);
    check("rst_din", 32'(bus.out_din), 32'h0);
    check("rst_sb", 32'({bus.out_sof, bus.out_eol, bus.out_eof}), 32'h0);
    check("rst_done", 32'(frame_done), 32'h0);
    check("rst_cnt", 32'(frame_cnt), 32'h0);
    check("rst_ck", frame_checksum, 32'h0);
    @(negedge clock);
    bus.in_empty = 1'b1;
    reset        = 1'b0;
    stream("post_rst", 8, 24'h100, 1'b0, 1'b0, 16'd1, 32'h0000_081C);

    // Frame counter wrap 0xFFFF -> 0
    @(negedge clock);
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clock);
    release dut.frame_cnt_q;
    @(negedge clock);
    check("wrap_preload", 32'(frame_cnt), 32'h0000_FFFF);
    stream("wrap", 8, 24'h1, 1'b0, 1'b0, 16'd0, 32'h0000_0024);

    // Constant-pixel frame checksum
    stream("ck_ff", 8, 24'hFF, 1'b0, 1'b1, 16'd1, 32'h0000_07F8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
